adpll_loop_filter: RTL and testbench
====================================

# adpll_loop_filter

Digital phase detector and gear-shifted PI loop filter that consumes the 12-bit TDC word (DCO-cycle count plus 1/32-period fraction per reference cycle) and produces the DCO tuning code. It accumulates the frequency-command minus measured-phase error, applies a proportional-plus-integral filter whose gains switch from acquisition to tracking once the loop settles, and flags lock. It sits directly downstream of the TDC digital stage and directly upstream of the DCO bank decoder.

## Interface
- FCW_W, 12: width of fcw and tdc_word; 7.5 unsigned fixed point, modulo 2^FCW_W
- ERR_W, 16: signed phase-error accumulator width
- INT_W, 20: signed integrator width
- OUT_W, 10: DCO code width; code mid-scale is 2^(OUT_W-1)
- LOCK_CYC, 16: consecutive in-threshold samples required to declare lock
- clk  in  1  clock; all state on posedge
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- en  in  1  loop enable
- tdc_valid  in  1  tdc_word is valid this cycle; one sample per pulse
- tdc_word  in  FCW_W  measured phase increment from the TDC
- fcw  in  FCW_W  frequency command word, same units as tdc_word
- kp_acq_sh, ki_acq_sh  in  4 each  proportional / integral right-shifts in ACQ
- kp_trk_sh, ki_trk_sh  in  4 each  proportional / integral right-shifts in TRACK
- lock_thr  in  8  unsigned lock threshold on |phase_err|
- dco_word  out  OUT_W  DCO tuning code
- dco_valid  out  1  one-cycle pulse: dco_word updated
- locked  out  1  state is TRACK
- state  out  2  IDLE=0, ACQ=1, TRACK=2

## Operation
- Stage 1 (tdc_valid & en): d = (fcw - tdc_word) mod 2^FCW_W, reinterpreted as signed [-2048, 2047]; phase_err <= sat_ERR_W(phase_err + d).
- Stage 2 (one cycle after stage 1): sh_p / sh_i selected by the current state (ACQ or TRACK gains); integ <= sat_INT_W(integ + (phase_err >>> sh_i)); sum = (phase_err >>> sh_p) + integ_next; dco_word <= clip(2^(OUT_W-1) + sum, 0, 2^OUT_W - 1); dco_valid <= 1.
- All shifts are arithmetic; saturation is symmetric to the signed width limits; no wrap anywhere after d.
- FSM:
  - IDLE → ACQ when en = 1.
  - ACQ → TRACK when lock_cnt reaches LOCK_CYC. lock_cnt increments on each stage-2 update with |phase_err| <= lock_thr and clears otherwise.
  - TRACK → ACQ when a stage-2 update sees |phase_err| > 4*lock_thr; lock_cnt clears.
  - Any state → IDLE when en = 0, with priority over all other transitions.
- Entering IDLE clears phase_err, lock_cnt and pipeline valids. integ and dco_word are held, so re-acquisition is bumpless.
- ACQ ↔ TRACK switches only the gains; integ is not modified.
- locked = (state == TRACK).

## Timing
- Reset values: dco_word = 2^(OUT_W-1) (512), dco_valid = 0, locked = 0, state = IDLE. phase_err, integ and lock_cnt are all 0.
- Latency: tdc_valid in cycle n gives phase_err in n+1 and dco_word plus the dco_valid pulse in n+2. Throughput is one sample per cycle.
- The FSM transition evaluated in a stage-2 cycle is visible on state/locked in that same cycle as dco_valid (registered together). Its gains apply from the next sample.
- tdc_valid while en = 0 is ignored. en falling with a sample in flight drops that sample: no dco_valid.
- Reset asserted mid-pipeline clears everything immediately. No dco_valid appears after release until a new tdc_valid arrives, at +2.

## Structure
- Package adpll_pkg holds: the state enum (IDLE/ACQ/TRACK); width localparams; the mid-scale constant; and the lock-loss multiplier (4).
- One sub-module, adpll_sat_add: a parameterised signed add with saturation, instanced for phase_err and integ.

## Test plan
- fcw=0x140, tdc_word=0x140 every cycle, lock_thr=2 → dco_word stays 512. locked=1 coincides with the 16th dco_valid.
- fcw=0x140, tdc_word=0x13F, kp_acq_sh=0, ki_acq_sh=4, one sample → phase_err=1 and dco_word=513, both at n+2.
- Wrap: fcw=0x001, tdc_word=0xFFF → d=+2, phase_err=2 (not -4094).
- Saturation: fcw=0x7FF, tdc_word=0x000 repeated, kp=0 → dco_word clips at 1023. phase_err saturates at 32767 and never wraps.
- Lock loss: in TRACK with lock_thr=4, inject d=+17 → state=ACQ and locked=0 on that sample's dco_valid cycle. integ is unchanged by the gear shift.
- rst_n pulsed low one cycle after tdc_valid → outputs reset asynchronously, no dco_valid follows. en low for 1 cycle → IDLE, phase_err=0, dco_word held.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL phase detector / loop filter.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int ADPLL_FCW_W    = 12;
  localparam int ADPLL_ERR_W    = 16;
  localparam int ADPLL_INT_W    = 20;
  localparam int ADPLL_OUT_W    = 10;
  localparam int ADPLL_LOCK_CYC = 16;

  // Lock is dropped when |phase_err| exceeds this multiple of lock_thr.
  localparam int LOCK_LOSS_MULT = 4;

  function automatic int mid_scale(input int out_w);
    return 1 << (out_w - 1);
  endfunction

  localparam int DCO_MID = mid_scale(ADPLL_OUT_W);

endpackage

// File: rtl/adpll_sat_add.sv
// Signed add that clamps to the most positive / most negative W-bit value.
module adpll_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] full;

  // One guard bit detects overflow; clamp toward the sign of the true sum.
  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    if (full[W] != full[W-1]) begin
      y = full[W] ? MIN_V : MAX_V;
    end else begin
      y = full[W-1:0];
    end
  end

endmodule

// File: rtl/adpll_loop_filter.sv
// Phase accumulator plus gear-shifted PI filter producing the DCO tuning code.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int FCW_W    = ADPLL_FCW_W,
  parameter int ERR_W    = ADPLL_ERR_W,
  parameter int INT_W    = ADPLL_INT_W,
  parameter int OUT_W    = ADPLL_OUT_W,
  parameter int LOCK_CYC = ADPLL_LOCK_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tdc_valid,
  input  logic [FCW_W-1:0] tdc_word,
  input  logic [FCW_W-1:0] fcw,
  input  logic [3:0]       kp_acq_sh,
  input  logic [3:0]       ki_acq_sh,
  input  logic [3:0]       kp_trk_sh,
  input  logic [3:0]       ki_trk_sh,
  input  logic [7:0]       lock_thr,
  output logic [OUT_W-1:0] dco_word,
  output logic             dco_valid,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int SUM_W = INT_W + 2;
  localparam int CNT_W = $clog2(LOCK_CYC + 1);
  localparam logic signed [SUM_W-1:0] MID      = SUM_W'(mid_scale(OUT_W));
  localparam logic signed [SUM_W-1:0] CODE_MAX = SUM_W'((1 << OUT_W) - 1);

  state_t                    cur_state;
  logic        [CNT_W-1:0]   lock_cnt;
  logic signed [ERR_W-1:0]   phase_err;
  logic signed [INT_W-1:0]   integ;
  logic                      s1_valid;

  logic signed [FCW_W-1:0]   d;
  logic signed [ERR_W-1:0]   d_ext;
  logic signed [ERR_W-1:0]   phase_err_sum;
  logic        [3:0]         sh_p;
  logic        [3:0]         sh_i;
  logic signed [ERR_W-1:0]   err_p;
  logic signed [ERR_W-1:0]   err_i;
  logic signed [INT_W-1:0]   err_i_ext;
  logic signed [INT_W-1:0]   integ_next;
  logic signed [SUM_W-1:0]   code_full;
  logic        [OUT_W-1:0]   code_clip;
  logic        [ERR_W:0]     err_mag_in;
  logic        [ERR_W:0]     abs_err;
  logic        [ERR_W:0]     loss_thr;
  logic        [CNT_W-1:0]   lock_cnt_inc;
  logic                      in_thr;
  logic                      lose_lock;

  // Modulo difference reinterpreted as signed: the only place wrap is allowed.
  assign d     = fcw - tdc_word;
  assign d_ext = {{(ERR_W-FCW_W){d[FCW_W-1]}}, d};

  adpll_sat_add #(.W(ERR_W)) u_err_add (
    .a (phase_err),
    .b (d_ext),
    .y (phase_err_sum)
  );

  assign sh_p      = (cur_state == TRACK) ? kp_trk_sh : kp_acq_sh;
  assign sh_i      = (cur_state == TRACK) ? ki_trk_sh : ki_acq_sh;
  assign err_p     = phase_err >>> sh_p;
  assign err_i     = phase_err >>> sh_i;
  assign err_i_ext = {{(INT_W-ERR_W){err_i[ERR_W-1]}}, err_i};

  adpll_sat_add #(.W(INT_W)) u_int_add (
    .a (integ),
    .b (err_i_ext),
    .y (integ_next)
  );

  // Proportional + integral around mid-scale, clipped to the DCO code range.
  always_comb begin
    code_full = {{(SUM_W-ERR_W){err_p[ERR_W-1]}}, err_p}
              + {{(SUM_W-INT_W){integ_next[INT_W-1]}}, integ_next}
              + MID;
    if (code_full < 0) begin
      code_clip = '0;
    end else if (code_full > CODE_MAX) begin
      code_clip = '1;
    end else begin
      code_clip = code_full[OUT_W-1:0];
    end
  end

  assign err_mag_in   = {phase_err[ERR_W-1], phase_err};
  assign abs_err      = err_mag_in[ERR_W] ? (~err_mag_in + 1'b1) : err_mag_in;
  assign loss_thr     = (ERR_W+1)'(lock_thr) * (ERR_W+1)'(LOCK_LOSS_MULT);
  assign in_thr       = abs_err <= (ERR_W+1)'(lock_thr);
  assign lose_lock    = abs_err > loss_thr;
  assign lock_cnt_inc = lock_cnt + 1'b1;

  // Two-stage datapath: accumulate phase error, then update integrator and code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_err <= '0;
      s1_valid  <= 1'b0;
      integ     <= '0;
      dco_word  <= MID[OUT_W-1:0];
      dco_valid <= 1'b0;
    end else begin
      dco_valid <= 1'b0;
      if (!en) begin
        // integ and dco_word are held so re-acquisition is bumpless.
        phase_err <= '0;
        s1_valid  <= 1'b0;
      end else begin
        s1_valid <= tdc_valid;
        if (tdc_valid) begin
          phase_err <= phase_err_sum;
        end
        if (s1_valid) begin
          integ     <= integ_next;
          dco_word  <= code_clip;
          dco_valid <= 1'b1;
        end
      end
    end
  end

  // Gear-shift FSM, evaluated on the same stage-2 update that refreshes dco_word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      lock_cnt  <= '0;
    end else if (!en) begin
      cur_state <= IDLE;
      lock_cnt  <= '0;
    end else begin
      case (cur_state)
        IDLE: cur_state <= ACQ;
        ACQ: begin
          if (s1_valid) begin
            if (in_thr) begin
              lock_cnt <= lock_cnt_inc;
              if (lock_cnt_inc == CNT_W'(LOCK_CYC)) begin
                cur_state <= TRACK;
              end
            end else begin
              lock_cnt <= '0;
            end
          end
        end
        TRACK: begin
          if (s1_valid && lose_lock) begin
            cur_state <= ACQ;
            lock_cnt  <= '0;
          end
        end
        default: begin
          cur_state <= IDLE;
          lock_cnt  <= '0;
        end
      endcase
    end
  end

  assign state  = cur_state;
  assign locked = (cur_state == TRACK);

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Randomized and directed bench for adpll_loop_filter against a per-sample model.
module tb_adpll_loop_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tdc_valid;
  logic [11:0] tdc_word;
  logic [11:0] fcw;
  logic [3:0]  kp_acq_sh, ki_acq_sh, kp_trk_sh, ki_trk_sh;
  logic [7:0]  lock_thr;
  logic [9:0]  dco_word;
  logic        dco_valid;
  logic        locked;
  logic [1:0]  state;

  adpll_loop_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tdc_valid (tdc_valid),
    .tdc_word  (tdc_word),
    .fcw       (fcw),
    .kp_acq_sh (kp_acq_sh),
    .ki_acq_sh (ki_acq_sh),
    .kp_trk_sh (kp_trk_sh),
    .ki_trk_sh (ki_trk_sh),
    .lock_thr  (lock_thr),
    .dco_word  (dco_word),
    .dco_valid (dco_valid),
    .locked    (locked),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the loop seen one sample at a time.
  int m_err, m_integ, m_dco, m_cnt, m_state;   // m_state: 0 idle, 1 acq, 2 track
  bit pending;                                  // a sample awaits its filter update
  int pend_err;                                 // phase error that update will see
  bit exp_valid;
  int n_dco_valid, lock_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x, input int w);
    int lim = 1 << (w - 1);
    if (x > lim - 1) return lim - 1;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic int wrap_diff(input logic [11:0] f, input logic [11:0] w);
    int dd = (int'(f) - int'(w)) & 32'hFFF;
    if (dd >= 2048) dd -= 4096;
    return dd;
  endfunction

  // Filter update for one sample, using the gains of the current mode.
  task automatic model_update(input int err);
    int sp, si, mag, code;
    sp = (m_state == 2) ? int'(kp_trk_sh) : int'(kp_acq_sh);
    si = (m_state == 2) ? int'(ki_trk_sh) : int'(ki_acq_sh);
    m_integ = sat(m_integ + (err >>> si), 20);
    code = 512 + (err >>> sp) + m_integ;
    m_dco = (code < 0) ? 0 : (code > 1023) ? 1023 : code;
    mag = (err < 0) ? -err : err;
    if (m_state == 1) begin
      m_cnt = (mag <= int'(lock_thr)) ? m_cnt + 1 : 0;
      if (m_cnt == 16) m_state = 2;
    end else if (m_state == 2 && mag > 4 * int'(lock_thr)) begin
      m_state = 1;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_integ = 0; m_dco = 512; m_cnt = 0; m_state = 0;
    pending = 0; exp_valid = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, dco_valid, exp_valid);
    check({tag, "_dco"}, dco_word, m_dco);
    check({tag, "_state"}, state, m_state);
    check({tag, "_locked"}, locked, (m_state == 2));
  endtask

  // Drive one clock's inputs, advance the model, then check after the edge.
  task automatic cycle(input bit e, input bit v, input logic [11:0] w, input string tag);
    en = e; tdc_valid = v; tdc_word = w;
    exp_valid = 0;
    if (!e) begin
      pending = 0; m_err = 0; m_cnt = 0; m_state = 0;
    end else begin
      if (pending) begin
        model_update(pend_err);
        exp_valid = 1;
      end
      if (m_state == 0) m_state = 1;
      pending = v;
      if (v) begin
        m_err = sat(m_err + wrap_diff(fcw, w), 16);
        pend_err = m_err;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (dco_valid) n_dco_valid++;
  endtask

  task automatic set_gains(input int pa, input int ia, input int pt, input int it);
    kp_acq_sh = 4'(pa); ki_acq_sh = 4'(ia); kp_trk_sh = 4'(pt); ki_trk_sh = 4'(it);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; tdc_valid = 1'b0; tdc_word = '0; fcw = '0;
    set_gains(2, 4, 4, 8);
    lock_thr = 8'd2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Matched frequency: code stays at mid-scale, lock on the 16th update.
    fcw = 12'h140;
    n_dco_valid = 0; lock_at = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 12'h140, "match");
      if (locked && lock_at == 0) lock_at = n_dco_valid;
    end
    check("lock_at_16th", lock_at, 16);
    check("match_mid", dco_word, 512);

    // Single sample of error +1, proportional shift 0.
    cycle(0, 0, 12'h0, "idle1");
    set_gains(0, 4, 4, 8);
    cycle(1, 1, 12'h13F, "one");
    cycle(1, 0, 12'h0, "one");
    check("one_dco_513", dco_word, 513);
    check("one_valid", dco_valid, 1);
    cycle(1, 0, 12'h0, "one_after");

    // Wrapped difference 0x001 - 0xFFF = +2.
    cycle(0, 0, 12'h0, "idle2");
    fcw = 12'h001;
    set_gains(0, 15, 4, 8);
    cycle(1, 1, 12'hFFF, "wrap");
    cycle(1, 0, 12'h0, "wrap");
    check("wrap_dco_514", dco_word, 514);

    // Large positive error: saturating accumulators, code clips at top.
    cycle(0, 0, 12'h0, "idle3");
    fcw = 12'h7FF;
    set_gains(0, 0, 0, 0);
    for (int i = 0; i < 25; i++) cycle(1, 1, 12'h000, "sat");
    cycle(1, 0, 12'h0, "sat_tail");
    check("sat_dco_1023", dco_word, 1023);

    // One cycle of en low: IDLE, code held.
    cycle(0, 0, 12'h0, "en_low");
    check("en_low_state", state, 0);
    check("en_low_hold", dco_word, 1023);

    // Reset in the middle of the pipeline.
    fcw = 12'h100;
    cycle(1, 1, 12'h0F0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 0, 12'h0, "post_rst");

    // Lock, then a +17 step with lock_thr=4 forces back to ACQ.
    fcw = 12'h200;
    lock_thr = 8'd4;
    set_gains(1, 3, 3, 6);
    for (int i = 0; i < 18; i++) cycle(1, 1, 12'h200, "lock2");
    check("lock2_state", state, 2);
    cycle(1, 1, 12'h1EF, "loss");
    cycle(1, 1, 12'h200, "loss");
    check("loss_state_acq", state, 1);
    check("loss_unlocked", locked, 0);
    check("loss_dco_514", dco_word, 514);
    cycle(1, 0, 12'h0, "loss");
    check("acq_gain_dco_522", dco_word, 522);

    // Randomized traffic with occasional enable drops and gain changes.
    for (int i = 0; i < 600; i++) begin
      int delta;
      bit e, v;
      logic [11:0] w;
      if (i % 60 == 0) begin
        fcw = 12'($urandom_range(0, 4095));
        lock_thr = 8'($urandom_range(1, 12));
        set_gains($urandom_range(0, 6), $urandom_range(0, 10),
                  $urandom_range(0, 8), $urandom_range(2, 12));
      end
      e = ($urandom_range(0, 49) != 0);
      v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) delta = int'($urandom_range(0, 4095));
      else delta = int'($urandom_range(0, 8)) - 4;
      w = 12'(int'(fcw) - delta);
      cycle(e, v, w, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
